pwm_servo_ramp: RTL and testbench

//  8-channel servo PWM generator for the cube-turning motors. Sits directly

---
 rtl/pwm_servo_ramp.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_servo_ramp.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_servo_ramp.sv
// pwm_servo_ramp: 8-channel servo PWM generator with a small register file.
// Each channel emits one pulse per frame. The pulse width, in 1 us ticks, moves
// toward a programmed target only at frame boundaries. Every frame therefore
// carries one complete pulse.
// Optional feature macro: PWM_RAMP_EN. When it is defined, the STEP registers
// exist and limit how far the width may move in one frame. When it is
// undefined, the width jumps to the target at the next boundary.
module pwm_servo_ramp #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_DIV    = CLK_HZ / 1_000_000,
   parameter int FRAME_TICKS = 20000,
   parameter int PW_MIN      = 500,
   parameter int PW_MAX      = 2500,
   parameter int PW_RST      = 1500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_in,
   input  logic [7:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] d_out,
   output logic        pwm0,
   output logic        pwm1,
   output logic        pwm2,
   output logic        pwm3,
   output logic        pwm4,
   output logic        pwm5,
   output logic        pwm6,
   output logic        pwm7
);

   localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FC_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_TICKS - 1);
   localparam logic [15:0]     W_MIN   = 16'(PW_MIN);
   localparam logic [15:0]     W_MAX   = 16'(PW_MAX);
   localparam logic [15:0]     W_RST   = 16'(PW_RST);

   localparam logic [7:0] A_EN   = 8'h30;
   localparam logic [7:0] A_BUSY = 8'h31;

   logic            wr_q;
   logic            wr_stb;
   logic            wr_tgt;
   logic            wr_en;
   logic [PS_W-1:0] prescaler;
   logic            tick;
   logic [FC_W-1:0] frame_cnt;
   logic            boundary;
   logic [7:0]      en;
   logic [7:0]      busy;
   logic [7:0]      pwm_q;
   logic [15:0]     tgt [8];
   logic [15:0]     cur [8];
   logic [31:0]     rd_data;
   logic            unused_hi;

`ifdef PWM_RAMP_EN
   logic            wr_step;
   logic [15:0]     step [8];
`endif

   // A write target is forced into the legal servo range, so the
   // output can never command a width the mechanics cannot handle.
   function automatic logic [15:0] clamp_pw(input logic [15:0] v);
      logic [15:0] res;
      res = v;
      if (v < W_MIN) res = W_MIN;
      else if (v > W_MAX) res = W_MAX;
      return res;
   endfunction

`ifdef PWM_RAMP_EN
   // One frame of slew. The 17-bit sums keep the carry and the borrow
   // visible, so a large step stops at the target and does not wrap past it.
   function automatic logic [15:0] slew_pw(input logic [15:0] c,
                                           input logic [15:0] t,
                                           input logic [15:0] s);
      logic [16:0] up;
      logic [16:0] dn;
      logic [15:0] res;
      up  = {1'b0, c} + {1'b0, s};
      dn  = {1'b0, c} - {1'b0, s};
      res = t;
      if (s != 16'd0) begin
         if (c < t) begin
            res = (up >= {1'b0, t}) ? t : up[15:0];
         end else if (c > t) begin
            res = (dn[16] || (dn[15:0] <= t)) ? t : dn[15:0];
         end
      end
      return res;
   endfunction
`endif

   // A level write request commits once, on its rising edge.
   assign wr_stb = wr & ~wr_q;
   assign wr_tgt = wr_stb && (addr[7:3] == 5'b00000);
   assign wr_en  = wr_stb && (addr == A_EN);
`ifdef PWM_RAMP_EN
   assign wr_step = wr_stb && (addr[7:3] == 5'b00010);
`endif

   assign tick     = (prescaler == PS_LAST);
   assign boundary = tick && (frame_cnt == FC_LAST);

   // Only the low half-word of the write bus carries register data.
   assign unused_hi = ^d_in[31:16];

   // Delayed copy of wr for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_q <= 1'b0;
      else      wr_q <= wr;
   end

   // Clock prescaler that generates the 1 us tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Tick position within the current frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (tick) begin
         if (frame_cnt == FC_LAST) frame_cnt <= '0;
         else                      frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Channel enable mask.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       en <= 8'h00;
      else if (wr_en) en <= d_in[7:0];
   end

   // Target widths. They are clamped on entry and used at the next boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 8; n++) tgt[n] <= W_RST;
      end else if (wr_tgt) begin
         tgt[addr[2:0]] <= clamp_pw(d_in[15:0]);
      end
   end

`ifdef PWM_RAMP_EN
   // Per-channel slew limit. A value of 0 means jump straight to the target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 8; n++) step[n] <= 16'd0;
      end else if (wr_step) begin
         step[addr[2:0]] <= d_in[15:0];
      end
   end
`endif

   // The output width changes only at the frame boundary, and it uses the
   // target and step values held before any write that lands on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 8; n++) cur[n] <= W_RST;
      end else if (boundary) begin
         for (int n = 0; n < 8; n++) begin
`ifdef PWM_RAMP_EN
            cur[n] <= slew_pw(cur[n], tgt[n], step[n]);
`else
            cur[n] <= tgt[n];
`endif
         end
      end
   end

   // Registered PWM compare. Clearing an enable drops its output on the next clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_q <= 8'h00;
      end else begin
         for (int n = 0; n < 8; n++) begin
            pwm_q[n] <= en[n] & (32'(frame_cnt) < 32'(cur[n]));
         end
      end
   end

   // A channel is busy while its output width has not yet reached its target.
   always_comb begin
      busy = 8'h00;
      for (int n = 0; n < 8; n++) busy[n] = (cur[n] != tgt[n]);
   end

   // Read-data decode. Unmapped addresses read as zero.
   always_comb begin
      rd_data = 32'h0;
      case (addr[7:4])
         4'h0: if (!addr[3]) rd_data = {16'h0, tgt[addr[2:0]]};
`ifdef PWM_RAMP_EN
         4'h1: if (!addr[3]) rd_data = {16'h0, step[addr[2:0]]};
`endif
         4'h2: if (!addr[3]) rd_data = {16'h0, cur[addr[2:0]]};
         4'h3: begin
            if (addr == A_EN)        rd_data = {24'h0, en};
            else if (addr == A_BUSY) rd_data = {24'h0, busy};
         end
         default: rd_data = 32'h0;
      endcase
   end

   // Read data register. It follows addr while rd is high and holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    d_out <= 32'h0;
      else if (rd) d_out <= rd_data;
   end

   assign pwm0 = pwm_q[0];
   assign pwm1 = pwm_q[1];
   assign pwm2 = pwm_q[2];
   assign pwm3 = pwm_q[3];
   assign pwm4 = pwm_q[4];
   assign pwm5 = pwm_q[5];
   assign pwm6 = pwm_q[6];
   assign pwm7 = pwm_q[7];

endmodule

// File: tb/tb_pwm_servo_ramp.sv
// tb_pwm_servo_ramp: directed and randomized bench for pwm_servo_ramp,
// using a scaled-down frame so that many frames fit in a short run.
module tb_pwm_servo_ramp;

   localparam int TD   = 3;
   localparam int FT   = 300;
   localparam int PMIN = 50;
   localparam int PMAX = 250;
   localparam int PRST = 150;
   localparam int P    = TD * FT;
`ifdef PWM_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] d_in;
   logic [7:0]  addr;
   logic        rd;
   logic        wr;
   logic [31:0] d_out;
   logic        pwm0, pwm1, pwm2, pwm3, pwm4, pwm5, pwm6, pwm7;
   logic [7:0]  pwm_vec;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int tgt_m [8];
   int cur_m [8];
   int step_m [8];
   int en_m;
   int cyc;
   bit wr_prev;
   int hi_cnt [8];
   int last_cnt [8];

   pwm_servo_ramp #(
      .TICK_DIV(TD), .FRAME_TICKS(FT), .PW_MIN(PMIN), .PW_MAX(PMAX), .PW_RST(PRST)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out),
      .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3),
      .pwm4(pwm4), .pwm5(pwm5), .pwm6(pwm6), .pwm7(pwm7)
   );

   assign pwm_vec = {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v);
      return (v < PMIN) ? PMIN : ((v > PMAX) ? PMAX : v);
   endfunction

   function automatic int next_w(input int c, input int t, input int s);
      if (!RAMP || s == 0) return t;
      if (c < t) return (c + s >= t) ? t : c + s;
      if (c > t) return (c - s <= t) ? t : c - s;
      return t;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [7:0] b;
      if (a <= 8'h07) return 32'(tgt_m[a[2:0]]);
      if (a >= 8'h10 && a <= 8'h17) return RAMP ? 32'(step_m[a[2:0]]) : 32'h0;
      if (a >= 8'h20 && a <= 8'h27) return 32'(cur_m[a[2:0]]);
      if (a == 8'h30) return 32'(en_m);
      if (a == 8'h31) begin
         b = 8'h00;
         for (int n = 0; n < 8; n++) b[n] = (cur_m[n] != tgt_m[n]);
         return {24'h0, b};
      end
      return 32'h0;
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d);
      if (a <= 8'h07) tgt_m[a[2:0]] = clampv(int'(d[15:0]));
      else if (a >= 8'h10 && a <= 8'h17) step_m[a[2:0]] = RAMP ? int'(d[15:0]) : 0;
      else if (a == 8'h30) en_m = int'(d[7:0]);
   endtask

   task automatic model_reset();
      for (int n = 0; n < 8; n++) begin
         tgt_m[n] = PRST; cur_m[n] = PRST; step_m[n] = 0; hi_cnt[n] = 0; last_cnt[n] = 0;
      end
      en_m = 0; cyc = 0; wr_prev = 1'b0;
   endtask

   // One clock: predict this edge, advance the model, then check the PWM vector.
   task automatic clk_step();
      logic [7:0]  exp_pwm;
      logic [7:0]  a_s;
      logic [31:0] d_s;
      int fc;
      bit commit;
      bit bnd;
      fc = (cyc / TD) % FT;
      for (int n = 0; n < 8; n++) exp_pwm[n] = en_m[n] && (fc < cur_m[n]);
      commit = wr && !wr_prev;
      bnd = ((cyc + 1) % P) == 0;
      a_s = addr;
      d_s = d_in;
      @(posedge clk);
      cyc++;
      if (bnd) for (int n = 0; n < 8; n++) cur_m[n] = next_w(cur_m[n], tgt_m[n], step_m[n]);
      if (commit) model_write(a_s, d_s);
      wr_prev = wr;
      #1;
      check("pwm", {24'h0, pwm_vec}, {24'h0, exp_pwm});
      for (int n = 0; n < 8; n++) hi_cnt[n] += int'(pwm_vec[n]);
      if (cyc % P == 0) begin
         for (int n = 0; n < 8; n++) begin last_cnt[n] = hi_cnt[n]; hi_cnt[n] = 0; end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) clk_step();
   endtask

   task automatic run_to_boundary();
      for (int i = 0; i < P; i++) begin
         clk_step();
         if (cyc % P == 0) break;
      end
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
      addr = a; d_in = d; wr = 1'b1;
      clk_step();
      wr = 1'b0;
      clk_step();
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
      logic [31:0] exp;
      addr = a; rd = 1'b1;
      exp = model_read(a);
      clk_step();
      rd = 1'b0;
      check($sformatf("rd_%02h", a), d_out, exp);
      v = d_out;
   endtask

   task automatic rd_const(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd_reg(a, v);
      check(tag, v, exp);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] held;
      rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 8'h00; d_in = 32'h0;
      model_reset();

      // Reset state
      #1 rst = 1'b0;
      #2;
      check("rst_dout", d_out, 32'h0);
      check("rst_pwm", {24'h0, pwm_vec}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      rd_const("rst_tgt0", 8'h00, 32'(PRST));
      rd_const("rst_cur7", 8'h27, 32'(PRST));
      rd_const("rst_en", 8'h30, 32'h0);
      rd_const("rst_busy", 8'h31, 32'h0);
      rd_const("rst_step0", 8'h10, 32'h0);
      rd_const("unmapped", 8'h40, 32'h0);

      // Every channel high for PW_RST ticks per frame
      wr_reg(8'h30, 32'hFF);
      run_to_boundary();
      run_to_boundary();
      for (int n = 0; n < 8; n++) check($sformatf("width_rst_%0d", n), 32'(last_cnt[n]), 32'(PRST * TD));

      // d_out holds while rd is low
      rd_reg(8'h30, v);
      held = model_read(8'h30);
      addr = 8'h27;
      idle(3);
      check("dout_hold", d_out, held);

      // Clamping of target writes
      wr_reg(8'h00, 32'd300);
      wr_reg(8'h01, 32'd10);
      rd_const("clamp_tgt0", 8'h00, 32'(PMAX));
      rd_const("clamp_tgt1", 8'h01, 32'(PMIN));
      rd_const("cur0_midframe", 8'h20, 32'(PRST));
      run_to_boundary();
      rd_const("clamp_cur0", 8'h20, 32'(PMAX));
      rd_const("clamp_cur1", 8'h21, 32'(PMIN));

      // Ramp up by 10 per frame
      wr_reg(8'h12, 32'd10);
      wr_reg(8'h02, 32'd200);
      for (int i = 0; i < 5; i++) begin
         run_to_boundary();
         rd_const($sformatf("ramp_cur2_%0d", i), 8'h22, RAMP ? 32'(160 + 10 * i) : 32'd200);
         rd_reg(8'h31, v);
         check($sformatf("ramp_busy2_%0d", i), {31'h0, v[2]}, {31'h0, (RAMP && i < 4)});
      end

      // Large step stops at the target, both up and down
      wr_reg(8'h13, 32'd30);
      wr_reg(8'h03, 32'd200);
      wr_reg(8'h15, 32'd30);
      wr_reg(8'h05, 32'd100);
      for (int i = 0; i < 2; i++) begin
         run_to_boundary();
         rd_const($sformatf("ovs_cur3_%0d", i), 8'h23, RAMP ? ((i == 0) ? 32'd180 : 32'd200) : 32'd200);
         rd_const($sformatf("ovs_cur5_%0d", i), 8'h25, RAMP ? ((i == 0) ? 32'd120 : 32'd100) : 32'd100);
      end

      // Target write on the boundary edge: old value used, new value stored
      while (cyc % P != P - 1) clk_step();
      wr_reg(8'h06, 32'd200);
      rd_const("bnd_cur6", 8'h26, 32'(PRST));
      rd_const("bnd_tgt6", 8'h06, 32'd200);
      run_to_boundary();
      rd_const("bnd_cur6_next", 8'h26, 32'd200);

      // Write held high commits once; a mid-frame change does not cut the pulse
      run_to_boundary();
      idle(20 * TD);
      addr = 8'h04; d_in = 32'd90; wr = 1'b1;
      clk_step();
      d_in = 32'd200;
      idle(9);
      wr = 1'b0;
      clk_step();
      rd_const("hold_tgt4", 8'h04, 32'd90);
      run_to_boundary();
      check("width4_cur_frame", 32'(last_cnt[4]), 32'(PRST * TD));
      run_to_boundary();
      check("width4_next_frame", 32'(last_cnt[4]), 32'(90 * TD));

      // Randomized register traffic
      for (int i = 0; i < 60; i++) begin
         logic [7:0]  a;
         logic [31:0] d;
         case ($urandom_range(0, 5))
            0: a = 8'($urandom_range(0, 7));
            1: a = 8'h10 + 8'($urandom_range(0, 7));
            2: a = 8'h20 + 8'($urandom_range(0, 7));
            3: a = 8'h30;
            4: a = 8'h31;
            default: a = 8'($urandom);
         endcase
         d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 320));
         if ($urandom_range(0, 1) == 1) wr_reg(a, d);
         else rd_reg(a, v);
         idle($urandom_range(0, 40));
      end
      run_to_boundary();
      run_to_boundary();
      for (int n = 0; n < 8; n++) rd_reg(8'h20 + 8'(n), v);
      rd_reg(8'h31, v);

      // Asynchronous reset in the middle of a pulse
      wr_reg(8'h30, 32'hFF);
      run_to_boundary();
      idle(10 * TD);
      rd_reg(8'h20, v);
      #2 rst = 1'b0;
      #1;
      check("async_pwm", {24'h0, pwm_vec}, 32'h0);
      check("async_dout", d_out, 32'h0);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("inrst_pwm", {24'h0, pwm_vec}, 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      wr_reg(8'h30, 32'h01);
      rd_const("post_rst_cur0", 8'h20, 32'(PRST));
      rd_const("post_rst_tgt1", 8'h01, 32'(PRST));
      run_to_boundary();
      check("post_rst_width0", 32'(last_cnt[0]), 32'(PRST * TD - 1));
      check("post_rst_width1", 32'(last_cnt[1]), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
